uart_reg_bridge: RTL and testbench
==================================

// Module: uart_reg_bridge
// PURPOSE
//   Responder at the far end of the UART byte interface. Consumes bytes from the UART receiver,
//   decodes 2/3-byte register-access frames, issues one register-bus write or read, and returns
//   a 1-byte response through the UART transmitter. Sits between the UART top and a register file.
//   Frames: WR = {CMD_WR, addr, data} -> ACK_BYTE; RD = {CMD_RD, addr} -> read data or NAK_BYTE.
// PARAMETERS
//   FRAME_TIMEOUT  1_000_000  clocks allowed between bytes of one frame (10 ms @ 100 MHz)
//   RD_TIMEOUT     255        clocks allowed from o_reg_rd_en to i_reg_rd_valid
//   CMD_WR         8'hA5      write command byte
//   CMD_RD         8'h5A      read command byte
//   ACK_BYTE       8'h06      write response
//   NAK_BYTE       8'h15      read-timeout response
// PORTS
//   i_clk           in   1  system clock
//   i_aresetn       in   1  reset, asynchronous, active-low
//   i_rx_data       in   8  received byte, valid while i_rx_done=1
//   i_rx_done       in   1  1-cycle pulse: byte received
//   o_tx_start      out  1  1-cycle pulse: start transmitting o_tx_data
//   o_tx_data       out  8  response byte, stable from o_tx_start until i_tx_done
//   i_tx_done       in   1  1-cycle pulse: transmitter finished
//   o_reg_addr      out  8  register address
//   o_reg_wdata     out  8  register write data
//   o_reg_wr_en     out  1  1-cycle write strobe
//   o_reg_rd_en     out  1  1-cycle read strobe
//   i_reg_rd_data   in   8  read data, valid while i_reg_rd_valid=1
//   i_reg_rd_valid  in   1  read data valid pulse
//   o_busy          out  1  1 whenever state != IDLE
//   o_frame_err     out  1  1-cycle pulse: frame aborted by FRAME_TIMEOUT
//   o_overrun       out  1  1-cycle pulse: byte arrived while not accepting bytes, dropped
// BEHAVIOUR
//   Reset: state IDLE; all outputs and internal registers 0. Reset mid-frame discards the frame;
//     no strobe or tx_start is issued afterwards.
//   FSM: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, WAIT_RD, SEND, WAIT_TX.
//   IDLE: on i_rx_done, if byte==CMD_WR or CMD_RD, latch the command -> GET_ADDR; otherwise drop
//     the byte silently (no NAK, no overrun).
//   GET_ADDR: on i_rx_done latch o_reg_addr; RD -> REG_RD, WR -> GET_DATA.
//   GET_DATA: on i_rx_done latch o_reg_wdata -> REG_WR.
//   REG_WR: o_reg_wr_en=1 for exactly 1 cycle; response=ACK_BYTE -> SEND.
//   REG_RD: o_reg_rd_en=1 for exactly 1 cycle -> WAIT_RD.
//   WAIT_RD: on i_reg_rd_valid latch i_reg_rd_data as the response -> SEND. After RD_TIMEOUT clocks
//     without valid: response=NAK_BYTE -> SEND. Valid in the expiry cycle wins.
//     i_reg_rd_valid outside WAIT_RD is ignored.
//   SEND: o_tx_start=1 for 1 cycle with o_tx_data=response -> WAIT_TX.
//   WAIT_TX: on i_tx_done -> IDLE. i_tx_done in any other state is ignored.
//   Latency: last WR byte i_rx_done at cycle N -> o_reg_wr_en at N+1 -> o_tx_start at N+2.
//     RD addr byte at N -> o_reg_rd_en at N+1; i_reg_rd_valid at M -> o_tx_start at M+1.
//   Frame timeout: one counter, cleared on every accepted byte, counts in GET_ADDR/GET_DATA.
//     Reaching FRAME_TIMEOUT-1 -> IDLE with o_frame_err pulse. i_rx_done in the expiry cycle wins
//     (byte accepted, counter cleared).
//   Overrun: i_rx_done in REG_WR/REG_RD/WAIT_RD/SEND/WAIT_TX -> byte dropped, o_overrun pulse.
//   o_reg_addr/o_reg_wdata hold their last values until overwritten. Counter widths use $clog2.
// STRUCTURE
//   uart_bridge_pkg: state enum (logic [2:0]), CMD/ACK/NAK default localparams.
//   Sub-module uart_bridge_timeout: loadable down-counter (clear, enable, expired) used for both
//     timeouts; sized by the larger of FRAME_TIMEOUT and RD_TIMEOUT. The FSM stays in this file.
// TESTING
//   1. RX A5,10,3C -> one o_reg_wr_en with addr 10, wdata 3C; o_tx_start with 06; o_busy falls after i_tx_done.
//   2. RX 5A,22; bench answers valid=1, data 7E 3 clk after rd_en -> o_tx_start with 7E at valid+1.
//   3. RX 5A,22; valid never answered -> after 255 clk o_tx_start with 15; no second rd_en.
//   4. RX A5,10 then silence FRAME_TIMEOUT clk (param set to 100) -> o_frame_err, IDLE, no wr_en.
//   5. RX byte during WAIT_TX -> o_overrun pulse, byte ignored; RX 77 in IDLE -> no response.
//   6. Assert i_aresetn=0 between addr and data bytes -> all outputs 0; no strobe after release.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and default constants for the UART register-access bridge.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_REG_WR,
    ST_REG_RD,
    ST_WAIT_RD,
    ST_SEND,
    ST_WAIT_TX
  } state_e;

  localparam int unsigned DEF_FRAME_TIMEOUT = 1_000_000;
  localparam int unsigned DEF_RD_TIMEOUT    = 255;
  localparam logic [7:0]  DEF_CMD_WR        = 8'hA5;
  localparam logic [7:0]  DEF_CMD_RD        = 8'h5A;
  localparam logic [7:0]  DEF_ACK_BYTE      = 8'h06;
  localparam logic [7:0]  DEF_NAK_BYTE      = 8'h15;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_bridge_timeout.sv
// Loadable down-counter shared by the inter-byte and read-response timeouts.
module uart_bridge_timeout #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Loading T-1 makes the expiry cycle the T-th cycle of waiting.
  assign expired = (count == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes UART register-access frames, drives one register-bus access and returns a 1-byte response.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
  parameter int unsigned RD_TIMEOUT    = DEF_RD_TIMEOUT,
  parameter logic [7:0]  CMD_WR        = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RD        = DEF_CMD_RD,
  parameter logic [7:0]  ACK_BYTE      = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE      = DEF_NAK_BYTE
) (
  input  logic       i_clk,
  input  logic       i_aresetn,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr_en,
  output logic       o_reg_rd_en,
  input  logic [7:0] i_reg_rd_data,
  input  logic       i_reg_rd_valid,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned TMR_MAX = max_u(FRAME_TIMEOUT, RD_TIMEOUT);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] FRAME_LOAD = TMR_W'(FRAME_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RD_LOAD    = TMR_W'(RD_TIMEOUT - 1);

  state_e     state, state_next;
  logic       cmd_is_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] response;

  logic       byte_accept;
  logic       frame_err;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       tmr_expired;
  logic [TMR_W-1:0] tmr_load;

  uart_bridge_timeout #(
    .WIDTH (TMR_W)
  ) u_timeout (
    .clk        (i_clk),
    .rst_n      (i_aresetn),
    .clear      (tmr_clear),
    .load_value (tmr_load),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    byte_accept = 1'b0;
    frame_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_rx_done && ((i_rx_data == CMD_WR) || (i_rx_data == CMD_RD))) begin
          byte_accept = 1'b1;
          state_next  = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        if (i_rx_done) begin
          byte_accept = 1'b1;
          state_next  = cmd_is_rd ? ST_REG_RD : ST_GET_DATA;
        end else if (tmr_expired) begin
          frame_err  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (i_rx_done) begin
          byte_accept = 1'b1;
          state_next  = ST_REG_WR;
        end else if (tmr_expired) begin
          frame_err  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_REG_WR:  state_next = ST_SEND;
      ST_REG_RD:  state_next = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (i_reg_rd_valid || tmr_expired) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so outputs read 0 straight out of reset.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      cmd_is_rd <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      response  <= '0;
    end else begin
      if (byte_accept) begin
        unique case (state)
          ST_IDLE:     cmd_is_rd <= (i_rx_data == CMD_RD);
          ST_GET_ADDR: reg_addr  <= i_rx_data;
          ST_GET_DATA: reg_wdata <= i_rx_data;
          default:     ;
        endcase
      end
      if (state == ST_REG_WR) begin
        response <= ACK_BYTE;
      end else if (state == ST_WAIT_RD) begin
        // Read data arriving in the expiry cycle takes priority over the NAK.
        if (i_reg_rd_valid) begin
          response <= i_reg_rd_data;
        end else if (tmr_expired) begin
          response <= NAK_BYTE;
        end
      end
    end
  end

  // One counter serves both waits: reloaded per accepted byte and when the read strobe fires.
  assign tmr_clear  = byte_accept || (state == ST_REG_RD);
  assign tmr_load   = (state == ST_REG_RD) ? RD_LOAD : FRAME_LOAD;
  assign tmr_enable = (state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_WAIT_RD);

  assign o_reg_addr  = reg_addr;
  assign o_reg_wdata = reg_wdata;
  assign o_tx_data   = response;
  assign o_reg_wr_en = (state == ST_REG_WR);
  assign o_reg_rd_en = (state == ST_REG_RD);
  assign o_tx_start  = (state == ST_SEND);
  assign o_busy      = (state != ST_IDLE);
  assign o_frame_err = frame_err;
  assign o_overrun   = i_rx_done && ((state == ST_REG_WR) || (state == ST_REG_RD) ||
                                     (state == ST_WAIT_RD) || (state == ST_SEND) ||
                                     (state == ST_WAIT_TX));

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomized frame-level bench for uart_reg_bridge with a transaction-level reference model.
module tb_uart_reg_bridge;

  localparam int unsigned FRAME_TO = 100;
  localparam int unsigned RD_TO    = 255;
  localparam logic [7:0]  CMD_WR   = 8'hA5;
  localparam logic [7:0]  CMD_RD   = 8'h5A;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data = '0;
  logic       reg_rd_valid = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_reg_bridge #(
    .FRAME_TIMEOUT (FRAME_TO),
    .RD_TIMEOUT    (RD_TO)
  ) dut (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_done      (rx_done),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .i_tx_done      (tx_done),
    .o_reg_addr     (reg_addr),
    .o_reg_wdata    (reg_wdata),
    .o_reg_wr_en    (reg_wr_en),
    .o_reg_rd_en    (reg_rd_en),
    .i_reg_rd_data  (reg_rd_data),
    .i_reg_rd_valid (reg_rd_valid),
    .o_busy         (busy),
    .o_frame_err    (frame_err),
    .o_overrun      (overrun)
  );

  int errors = 0;
  int checks = 0;

  // Reference register file and observed-event log.
  logic [7:0] regs [256];
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, ovr_cnt = 0, ferr_cnt = 0;
  int wr_cyc, rd_cyc, tx_cyc, ferr_cyc;
  logic [7:0] wr_addr, wr_data, rd_addr, tx_byte, tx_at_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, observe outputs at the falling edge.
  task automatic step(input logic rxd, input logic [7:0] rxb, input logic vld,
                      input logic [7:0] vdat, input logic txd);
    @(posedge clk);
    #1;
    cyc++;
    rx_done      = rxd;
    rx_data      = rxb;
    reg_rd_valid = vld;
    reg_rd_data  = vdat;
    tx_done      = txd;
    @(negedge clk);
    if (reg_wr_en) begin wr_cnt++; wr_cyc = cyc; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd_en) begin rd_cnt++; rd_cyc = cyc; rd_addr = reg_addr; end
    if (tx_start)  begin tx_cnt++; tx_cyc = cyc; tx_byte = tx_data; end
    if (overrun)   ovr_cnt++;
    if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    if (txd)       tx_at_done = tx_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    step(1'b1, b, 1'b0, 8'h00, 1'b0);
  endtask

  // Completes the transmit handshake; optionally injects a byte while the response is in flight.
  task automatic finish_tx(input logic [7:0] exp_byte, input int hold, input bit inject);
    int ovr0 = ovr_cnt;
    if (inject) begin
      step(1'b1, CMD_WR, 1'b0, 8'h00, 1'b0);
      check("overrun_wait_tx", ovr_cnt - ovr0, 1);
    end
    idle(hold);
    check("busy_in_wait_tx", busy, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("tx_data_stable", tx_at_done, exp_byte);
    idle(1);
    check("busy_after_tx_done", busy, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap_a, input int gap_d);
    int wr0 = wr_cnt, tx0 = tx_cnt, n;
    send_byte(CMD_WR, 0);
    send_byte(a, gap_a);
    send_byte(d, gap_d);
    n = cyc;
    for (int i = 0; i < 8 && tx_cnt == tx0; i++) idle(1);
    check("wr_count", wr_cnt - wr0, 1);
    check("wr_addr", wr_addr, a);
    check("wr_data", wr_data, d);
    check("wr_latency", wr_cyc - n, 1);
    check("wr_tx_count", tx_cnt - tx0, 1);
    check("wr_ack", tx_byte, ACK);
    check("wr_tx_latency", tx_cyc - n, 2);
    regs[a] = d;
    finish_tx(ACK, $urandom_range(0, 3), 1'b0);
  endtask

  // lat = 0 means the register file never answers; ovr_at > 0 injects a byte that many cycles after rd_en.
  task automatic do_read(input logic [7:0] a, input int lat, input int gap, input int ovr_at);
    int rd0 = rd_cnt, tx0 = tx_cnt, wr0 = wr_cnt, ovr0 = ovr_cnt, n;
    logic [7:0] exp_byte;
    int exp_tx;
    logic vld, rxd;
    send_byte(CMD_RD, 0);
    send_byte(a, gap);
    n = cyc;
    for (int i = 0; i < 400 && tx_cnt == tx0; i++) begin
      vld = (lat != 0) && (rd_cnt != rd0) && (cyc + 1 == rd_cyc + lat);
      rxd = (ovr_at != 0) && (rd_cnt != rd0) && (cyc + 1 == rd_cyc + ovr_at);
      step(rxd, 8'hC3, vld, regs[a], 1'b0);
    end
    check("rd_count", rd_cnt - rd0, 1);
    check("rd_addr", rd_addr, a);
    check("rd_latency", rd_cyc - n, 1);
    check("rd_no_write", wr_cnt - wr0, 0);
    check("rd_tx_count", tx_cnt - tx0, 1);
    if (lat != 0 && lat <= int'(RD_TO)) begin
      exp_byte = regs[a];
      exp_tx   = rd_cyc + lat + 1;
    end else begin
      exp_byte = NAK;
      exp_tx   = rd_cyc + int'(RD_TO) + 1;
    end
    check("rd_response", tx_byte, exp_byte);
    check("rd_tx_cycle", tx_cyc, exp_tx);
    if (ovr_at != 0) check("overrun_wait_rd", ovr_cnt - ovr0, 1);
    finish_tx(exp_byte, $urandom_range(0, 3), 1'b0);
    check("rd_single_strobe", rd_cnt - rd0, 1);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, tx0, ovr0, ferr0, n;
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_reg_addr", reg_addr, 8'h00);
    check("reset_strobes", {tx_start, reg_wr_en, reg_rd_en, frame_err, overrun}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed write and reads.
    do_write(8'h10, 8'h3C, 0, 0);
    do_read(8'h22, 3, 0, 0);
    do_read(8'h22, 0, 0, 0);
    do_read(8'h10, int'(RD_TO), 1, 0);
    do_read(8'h10, int'(RD_TO) + 1, 0, 0);
    do_read(8'h10, 5, 0, 2);

    // Frame timeout in GET_DATA, then in GET_ADDR.
    wr0 = wr_cnt; ferr0 = ferr_cnt;
    send_byte(CMD_WR, 0);
    send_byte(8'h10, 0);
    n = cyc;
    for (int i = 0; i < 200 && ferr_cnt == ferr0; i++) idle(1);
    check("ferr_count", ferr_cnt - ferr0, 1);
    check("ferr_cycle", ferr_cyc - n, FRAME_TO);
    idle(1);
    check("ferr_idle", busy, 1'b0);
    check("ferr_no_write", wr_cnt - wr0, 0);

    ferr0 = ferr_cnt;
    send_byte(CMD_RD, 0);
    n = cyc;
    for (int i = 0; i < 200 && ferr_cnt == ferr0; i++) idle(1);
    check("ferr_addr_cycle", ferr_cyc - n, FRAME_TO);

    // A byte landing in the expiry cycle is still accepted.
    ferr0 = ferr_cnt;
    do_write(8'h33, 8'h44, FRAME_TO - 1, FRAME_TO - 1);
    check("ferr_edge_none", ferr_cnt - ferr0, 0);

    // Overrun while waiting for tx_done; the byte is not taken as a command.
    wr0 = wr_cnt; tx0 = tx_cnt;
    send_byte(CMD_WR, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    for (int i = 0; i < 8 && tx_cnt == tx0; i++) idle(1);
    regs[8'h55] = 8'h66;
    finish_tx(ACK, 1, 1'b1);
    tx0 = tx_cnt; ovr0 = ovr_cnt;
    idle(5);
    check("overrun_byte_dropped", busy, 1'b0);

    // Non-command byte and stray read-valid in IDLE produce nothing.
    send_byte(8'h77, 0);
    step(1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(10);
    check("junk_no_tx", tx_cnt - tx0, 0);
    check("junk_no_overrun", ovr_cnt - ovr0, 0);
    check("junk_idle", busy, 1'b0);

    // Reset between address and data bytes.
    wr0 = wr_cnt; tx0 = tx_cnt;
    send_byte(CMD_WR, 0);
    send_byte(8'h44, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_addr", reg_addr, 8'h00);
    check("midreset_wdata", reg_wdata, 8'h00);
    check("midreset_tx_data", tx_data, 8'h00);
    check("midreset_strobes", {tx_start, reg_wr_en, reg_rd_en, frame_err, overrun}, 5'b0);
    idle(2);
    rst_n = 1'b1;
    send_byte(8'h99, 0);
    idle(10);
    check("postreset_no_write", wr_cnt - wr0, 0);
    check("postreset_no_tx", tx_cnt - tx0, 0);
    check("postreset_idle", busy, 1'b0);

    // Randomized mix of writes and reads against the reference register file.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
      end else begin
        do_read(8'($urandom), $urandom_range(1, 20), $urandom_range(0, 4), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
